fsquare: RTL and testbench

FSQUARE -- requirements
Module: fsquare

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_round_rne.sv | 62 ++++++
 rtl/fsquare.sv | 146 ++++++++++++++
 tb/tb_fsquare.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, bias, special
// encodings and the iterative-unit FSM state type.
package fpu_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fpu_state_e;

endpackage

// File: rtl/fpu_round_rne.sv
// Normalises a 48-bit significand product (1.x * 1.x, so the leading one is
// at bit 47 or 46), rounds to nearest-even and produces the biased exponent
// field plus saturation flags. Purely combinational.
module fpu_round_rne
    import fpu_pkg::*;
(
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,   // 2*e_s - bias, before normalisation
    output logic [22:0]       frac,
    output logic [7:0]        exp_out,
    output logic              overflow,
    output logic              underflow
);

    logic [23:0]       sig;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              round_up;
    logic [24:0]       sig_rnd;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_final;

    // Normalise, round to nearest-even, fold any rounding carry into the exponent.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        sig      = prod[46:23];
        guard    = prod[22];
        rnd      = prod[21];
        sticky   = |prod[20:0];
        e_norm   = exp_in;
        frac     = '0;
        e_final  = exp_in;

        if (prod[47]) begin
            sig    = prod[47:24];
            guard  = prod[23];
            rnd    = prod[22];
            sticky = |prod[21:0];
            e_norm = exp_in + 10'sd1;
        end

        // Round up above the halfway point, or at exactly half when LSB is odd.
        round_up = guard & (rnd | sticky | sig[0]);
        sig_rnd  = {1'b0, sig} + {24'd0, round_up};

        if (sig_rnd[24]) begin
            // 1.111..1 rounded up to 10.000..0: fraction is zero, exponent +1.
            frac    = '0;
            e_final = e_norm + 10'sd1;
        end else begin
            frac    = sig_rnd[22:0];
            e_final = e_norm;
        end

        overflow  = (e_final >= 10'sd255);
        underflow = (e_final <= 10'sd0);
        exp_out   = e_final[7:0];
    end

endmodule

// File: rtl/fsquare.sv
// Iterative single-precision squarer: 24 shift-add steps on the significand,
// one rounding cycle, then a held result with valid/ready handshake.
module fsquare
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] s,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        overflow,
    output logic        underflow
);

    fpu_state_e        state, state_nxt;
    logic [31:0]       s_q;
    logic [4:0]        cnt;
    logic [47:0]       acc;
    logic [47:0]       acc_nxt;
    logic [23:0]       mant;
    logic [47:0]       mant_ext;
    logic signed [9:0] exp_base;
    logic [22:0]       rnd_frac;
    logic [7:0]        rnd_exp;
    logic              rnd_ov;
    logic              rnd_uf;
    logic [31:0]       res_d;
    logic              res_ov;
    logic              res_uf;
    logic              res_sign;
    logic              done_hs;
    logic [31:0]       d_q;
    logic              ov_q;
    logic              uf_q;
    logic              out_valid_q;

    assign mant     = {1'b1, s_q[22:0]};
    assign mant_ext = {24'd0, mant};
    assign acc_nxt  = acc + (mant[cnt] ? (mant_ext << cnt) : 48'd0);
    assign exp_base = $signed({1'b0, s_q[30:23], 1'b0}) - 10'sd127;
    // Sign of s*s is sign^sign, which is always zero.
    assign res_sign = s_q[31] ^ s_q[31];
    assign done_hs  = out_valid_q & out_ready;

    fpu_round_rne u_round (
        .prod      (acc),
        .exp_in    (exp_base),
        .frac      (rnd_frac),
        .exp_out   (rnd_exp),
        .overflow  (rnd_ov),
        .underflow (rnd_uf)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: accept, 24 multiply steps, round, hold until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid)       state_nxt = MUL;
            MUL:   if (cnt == 5'd23)   state_nxt = ROUND;
            ROUND:                     state_nxt = DONE;
            DONE:  if (done_hs)        state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Output decode: only IDLE can take a new operand.
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Result selection with special-case priority NaN > inf > zero/denormal > normal.
    always_comb begin
        res_d  = POS_ZERO;
        res_ov = 1'b0;
        res_uf = 1'b0;
        if (s_q[30:23] == 8'hFF && s_q[22:0] != 23'd0) begin
            res_d = QNAN;
        end else if (s_q[30:23] == 8'hFF) begin
            res_d = POS_INF;
        end else if (s_q[30:23] == 8'h00) begin
            res_d = POS_ZERO;
        end else if (rnd_ov) begin
            res_d  = POS_INF;
            res_ov = 1'b1;
        end else if (rnd_uf) begin
            res_d  = POS_ZERO;
            res_uf = 1'b1;
        end else begin
            res_d = {res_sign, rnd_exp, rnd_frac};
        end
    end

    // Datapath: capture operand, accumulate partial products, register result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q  <= '0;
            cnt  <= '0;
            acc  <= '0;
            d_q  <= '0;
            ov_q <= 1'b0;
            uf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    s_q <= s;
                    cnt <= '0;
                    acc <= '0;
                end
                MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    d_q  <= res_d;
                    ov_q <= res_ov;
                    uf_q <= res_uf;
                end
                default: ;
            endcase
        end
    end

    // out_valid rises on the edge after DONE is entered and drops on the
    // handshake edge, giving a fixed 26-edge accept-to-valid latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) out_valid_q <= 1'b0;
        else       out_valid_q <= (state == DONE) && !done_hs;
    end

    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign overflow  = ov_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_fsquare.sv
// Directed self-checking bench for fsquare.
module tb_fsquare;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [31:0] s;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    fsquare dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .s         (s),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Present an operand and let the next rising edge accept it.
    task automatic accept(input logic [31:0] op);
        int waited;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b1;
        s        = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 60) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] op,
                          input logic [31:0] exp_d, input logic exp_ov, input logic exp_uf);
        int edges;
        accept(op);
        wait_out(edges);
        total++;
        if (edges !== 26) begin
            bad++;
            $display("FAIL %s latency: got %0d edges, want 26", name, edges);
        end
        total++;
        if (d !== exp_d) begin
            bad++;
            $display("FAIL %s d: got %08h, want %08h", name, d, exp_d);
        end
        total++;
        if (overflow !== exp_ov || underflow !== exp_uf) begin
            bad++;
            $display("FAIL %s flags: got ov=%b uf=%b, want ov=%b uf=%b",
                     name, overflow, underflow, exp_ov, exp_uf);
        end
        release_out();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s handshake: got out_valid=%b in_ready=%b, want 0 1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        int edges;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 32'h0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b d=%08h ov=%b uf=%b, want 1 0 00000000 0 0",
                     in_ready, out_valid, d, overflow, underflow);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        // First edge after release must accept.
        in_valid = 1'b1;
        s        = 32'h4040_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL first_accept: got in_ready=%b, want 0", in_ready);
        end
        wait_out(edges);
        total++;
        if (edges !== 26 || d !== 32'h4110_0000) begin
            bad++;
            $display("FAIL first_op: got %0d edges d=%08h, want 26 41100000", edges, d);
        end
        release_out();
    endtask

    task automatic test_values();
        run_op("three",      32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0);
        run_op("neg_two",    32'hC000_0000, 32'h4080_0000, 1'b0, 1'b0);
        run_op("one_half",   32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0);
        run_op("one",        32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
        run_op("one_ulp",    32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0);
        run_op("round_up",   32'h3F80_0801, 32'h3F80_1003, 1'b0, 1'b0);
        run_op("tie_even",   32'h3F80_0800, 32'h3F80_1000, 1'b0, 1'b0);
    endtask

    task automatic test_specials();
        run_op("overflow",   32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
        run_op("underflow",  32'h1F80_0000, 32'h0000_0000, 1'b0, 1'b1);
        run_op("nan",        32'h7F80_0001, 32'h7FC0_0000, 1'b0, 1'b0);
        run_op("neg_inf",    32'hFF80_0000, 32'h7F80_0000, 1'b0, 1'b0);
        run_op("denormal",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int edges;
        int seen;
        accept(32'h4040_0000);
        wait_out(edges);
        in_valid = 1'b1;
        s        = 32'h3FC0_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (d !== 32'h4110_0000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_%0d: got d=%08h in_ready=%b out_valid=%b, want 41100000 0 1",
                         i, d, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        release_out();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL bp_ignored_input: got %0d busy cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        accept(32'hC000_0000);
        wait_out(edges);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        s         = 32'h3FC0_0000;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_complete: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: got in_ready=%b, want 0", in_ready);
        end
        wait_out(edges);
        total++;
        if (edges !== 26 || d !== 32'h4010_0000) begin
            bad++;
            $display("FAIL b2b_result: got %0d edges d=%08h, want 26 40100000", edges, d);
        end
        release_out();
    endtask

    task automatic test_reset_mid_op();
        int seen;
        accept(32'h4040_0000);
        repeat (12) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 32'h0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got in_ready=%b out_valid=%b d=%08h ov=%b uf=%b, want 1 0 00000000 0 0",
                     in_ready, out_valid, d, overflow, underflow);
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL aborted_op: got %0d busy cycles, want 0", seen);
        end
        run_op("after_reset", 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = 32'h0;
        test_reset();
        test_values();
        test_specials();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
